// File: rtl/carfield_mem_demux.sv
`default_nettype none
// ============================================================================
// Module   : carfield_mem_demux
// Brief    : Address-decoding req/gnt/rvalid demultiplexer with in-order
//            response tracking and an internal decode-error responder.
// Revision : 1.0 - initial release
// ============================================================================
module carfield_mem_demux #(
    parameter int unsigned NumRules       = 4,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumRules-1:0]             rule_en_i,
    input  logic [NumRules*AddrWidth-1:0]   rule_base_i,
    input  logic [NumRules*AddrWidth-1:0]   rule_size_i,
    input  logic                            req_i,
    input  logic [AddrWidth-1:0]            addr_i,
    input  logic                            we_i,
    input  logic [DataWidth-1:0]            wdata_i,
    input  logic [DataWidth/8-1:0]          be_i,
    output logic                            gnt_o,
    output logic                            rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            err_o,
    output logic [NumRules-1:0]             port_req_o,
    output logic [AddrWidth-1:0]            port_addr_o,
    output logic                            port_we_o,
    output logic [DataWidth-1:0]            port_wdata_o,
    output logic [DataWidth/8-1:0]          port_be_o,
    input  logic [NumRules-1:0]             port_gnt_i,
    input  logic [NumRules-1:0]             port_rvalid_i,
    input  logic [NumRules*DataWidth-1:0]   port_rdata_i,
    input  logic [NumRules-1:0]             port_err_i
);

    localparam int unsigned      c_TGT_W   = $clog2(NumRules + 1);
    localparam int unsigned      c_CNT_W   = $clog2(MaxOutstanding + 1);
    localparam logic [c_TGT_W-1:0] c_ERR_TGT = c_TGT_W'(NumRules);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MaxOutstanding);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_TGT_W-1:0]   r_last;
    logic                 r_err_pend;

    logic [NumRules-1:0]  w_match;
    logic [c_TGT_W-1:0]   w_tgt;
    logic                 w_is_err;
    logic                 w_cnt_nz;
    logic                 w_last_err;
    logic                 w_port_rvalid;
    logic [DataWidth-1:0] w_port_rdata;
    logic                 w_port_err;
    logic [NumRules-1:0]  w_rsp_mask;
    logic                 w_tgt_gnt;
    logic                 w_order_ok;
    logic                 w_room_ok;
    logic                 w_issue;

    // ------------------------------------------------------------------
    // Address decode: offset compare avoids any base+size overflow path
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NumRules; gi++) begin : g_rule
        logic [AddrWidth-1:0] w_base;
        logic [AddrWidth-1:0] w_size;
        logic [AddrWidth-1:0] w_off;

        assign w_base       = rule_base_i[gi*AddrWidth +: AddrWidth];
        assign w_size       = rule_size_i[gi*AddrWidth +: AddrWidth];
        assign w_off        = addr_i - w_base;
        assign w_match[gi]  = rule_en_i[gi] && (addr_i >= w_base) && (w_off < w_size);
    end

    // Descending scan so the lowest matching index is the final winner
    always_comb begin
        w_tgt = c_ERR_TGT;
        for (int i = int'(NumRules) - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_tgt = c_TGT_W'(i);
            end
        end
    end

    assign w_is_err   = (w_tgt == c_ERR_TGT);
    assign w_cnt_nz   = (r_cnt != '0);
    assign w_last_err = (r_last == c_ERR_TGT);

    // ------------------------------------------------------------------
    // Response path: pass-through from the port that owns the outstanding
    // transactions; everything else is dropped
    // ------------------------------------------------------------------
    always_comb begin
        w_port_rvalid = 1'b0;
        w_port_rdata  = '0;
        w_port_err    = 1'b0;
        w_rsp_mask    = '0;
        for (int i = 0; i < int'(NumRules); i++) begin
            if (r_last == c_TGT_W'(i)) begin
                w_port_rvalid = port_rvalid_i[i];
                w_port_rdata  = port_rdata_i[i*DataWidth +: DataWidth];
                w_port_err    = port_err_i[i];
                w_rsp_mask[i] = w_cnt_nz;
            end
        end
    end

    assign rvalid_o = w_last_err ? r_err_pend : (w_port_rvalid && w_cnt_nz);
    assign rdata_o  = (w_last_err || !w_cnt_nz) ? '0 : w_port_rdata;
    assign err_o    = w_last_err ? r_err_pend : (w_port_err && w_cnt_nz);

    // ------------------------------------------------------------------
    // Issue control: a new target may start in the very cycle the final
    // outstanding response of the previous target retires
    // ------------------------------------------------------------------
    assign w_order_ok = !w_cnt_nz
                     || (w_tgt == r_last)
                     || ((r_cnt == c_CNT_ONE) && rvalid_o);
    assign w_room_ok  = (r_cnt < c_CNT_MAX) || rvalid_o;
    assign w_issue    = req_i && w_order_ok && w_room_ok;

    always_comb begin
        port_req_o = '0;
        w_tgt_gnt  = 1'b0;
        for (int i = 0; i < int'(NumRules); i++) begin
            if (w_tgt == c_TGT_W'(i)) begin
                port_req_o[i] = w_issue;
                w_tgt_gnt     = port_gnt_i[i];
            end
        end
    end

    assign gnt_o        = w_issue && (w_is_err || w_tgt_gnt);

    assign port_addr_o  = addr_i;
    assign port_we_o    = we_i;
    assign port_wdata_o = wdata_i;
    assign port_be_o    = be_i;

    // ------------------------------------------------------------------
    // Outstanding tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_last     <= '0;
            r_err_pend <= 1'b0;
        end else begin
            if (gnt_o) begin
                r_last <= w_tgt;
            end
            r_err_pend <= gnt_o && w_is_err;
            case ({gnt_o, rvalid_o})
                2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
                2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_stray_rvalid : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ((port_rvalid_i & ~w_rsp_mask) == '0)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_carfield_mem_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_carfield_mem_demux
// Brief    : Scoreboard bench for carfield_mem_demux with latency-controlled
//            subordinate port models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_carfield_mem_demux;

    localparam int NR = 4;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int MO = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NR-1:0]     rule_en_i;
    logic [NR*AW-1:0]  rule_base_i;
    logic [NR*AW-1:0]  rule_size_i;
    logic              req_i;
    logic [AW-1:0]     addr_i;
    logic              we_i;
    logic [DW-1:0]     wdata_i;
    logic [DW/8-1:0]   be_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic [NR-1:0]     port_req_o;
    logic [AW-1:0]     port_addr_o;
    logic              port_we_o;
    logic [DW-1:0]     port_wdata_o;
    logic [DW/8-1:0]   port_be_o;
    logic [NR-1:0]     port_gnt_i;
    wire  [NR-1:0]     port_rvalid_i;
    wire  [NR*DW-1:0]  port_rdata_i;
    logic [NR-1:0]     port_err_i;

    always #5 clk_i = ~clk_i;

    carfield_mem_demux #(
        .NumRules(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rule_en_i(rule_en_i), .rule_base_i(rule_base_i), .rule_size_i(rule_size_i),
        .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .port_req_o(port_req_o), .port_addr_o(port_addr_o), .port_we_o(port_we_o),
        .port_wdata_o(port_wdata_o), .port_be_o(port_be_o),
        .port_gnt_i(port_gnt_i), .port_rvalid_i(port_rvalid_i),
        .port_rdata_i(port_rdata_i), .port_err_i(port_err_i)
    );

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;
    logic [NR-1:0] hold = '0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;
    exp_t        sb_q[$];
    logic [31:0] exp_ctr [NR];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Subordinate port models: accept every request, answer in order one
    // cycle after grant unless held; data = CAFE_0000 + port*256 + sequence.
    for (genvar p = 0; p < NR; p++) begin : g_port
        logic [DW-1:0] q_data[$];
        int unsigned   q_cyc[$];
        logic [31:0]   ctr = 0;
        logic          rv  = 1'b0;
        logic [DW-1:0] rd  = '0;

        assign port_rvalid_i[p]          = rv;
        assign port_rdata_i[p*DW +: DW]  = rd;

        always begin
            @(negedge clk_i);
            #1;
            if (q_data.size() > 0 && !hold[p] && (cyc - q_cyc[0] >= 1)) begin
                rv = 1'b1;
                rd = q_data[0];
            end else begin
                rv = 1'b0;
                rd = '0;
            end
            #3;
            if (rv) begin
                void'(q_data.pop_front());
                void'(q_cyc.pop_front());
            end
            if (rst_ni && port_req_o[p] && port_gnt_i[p]) begin
                ctr = ctr + 1;
                q_data.push_back(32'hCAFE0000 + 32'(p * 256) + ctr);
                q_cyc.push_back(cyc);
            end
        end
    end

    // Response monitor: every rvalid_o must match the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #4;
            if (rst_ni && rvalid_o) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected: got rvalid rdata=%h err=%b, expected no response", rdata_o, err_o);
                end else begin
                    e = sb_q.pop_front();
                    if ({rdata_o, err_o} !== {e.data, e.err}) begin
                        failures++;
                        $display("FAIL rsp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                                 rdata_o, err_o, e.data, e.err);
                    end
                end
            end
        end
    end

    function automatic void push_exp(input int p);
        exp_t e;
        if (p < NR) begin
            exp_ctr[p] = exp_ctr[p] + 1;
            e.data = 32'hCAFE0000 + 32'(p * 256) + exp_ctr[p];
            e.err  = 1'b0;
        end else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        sb_q.push_back(e);
    endfunction

    task automatic issue(input logic [AW-1:0] a, input int exp_port, output int waits);
        logic [NR-1:0] exp_req;
        bit done;
        done  = 0;
        waits = 0;
        exp_req = '0;
        if (exp_port < NR) exp_req[exp_port] = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk_i);
            req_i  = 1'b1;
            addr_i = a;
            #4;
            if (gnt_o) begin
                done = 1;
                checks++;
                if (port_req_o !== exp_req || port_addr_o !== a) begin
                    failures++;
                    $display("FAIL issue_route: addr=%h got port_req=%b port_addr=%h, expected port_req=%b",
                             a, port_req_o, port_addr_o, exp_req);
                end
                push_exp(exp_port);
            end else begin
                waits++;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: addr=%h got no gnt_o, expected grant within 60 cycles", a);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(negedge clk_i);
        req_i = 1'b0;
        while (sb_q.size() != 0 && k < 100) begin
            @(posedge clk_i);
            k++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d responses pending, expected 0", sb_q.size());
        end
        repeat (2) @(posedge clk_i);
    endtask

    // Hold a request that must stall for n cycles, then release the port
    // holding the pending response and require the grant in that same cycle.
    task automatic stall_then_release(input logic [AW-1:0] a, input int exp_port,
                                      input int rel_port, input string name);
        logic [NR-1:0] exp_req;
        exp_req = '0;
        exp_req[exp_port] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            req_i  = 1'b1;
            addr_i = a;
            #4;
            checks++;
            if (gnt_o !== 1'b0 || port_req_o !== '0) begin
                failures++;
                $display("FAIL %s_stall: got gnt=%b port_req=%b, expected gnt=0 port_req=0",
                         name, gnt_o, port_req_o);
            end
        end
        @(negedge clk_i);
        hold[rel_port] = 1'b0;
        #4;
        checks++;
        if (gnt_o !== 1'b1 || rvalid_o !== 1'b1 || port_req_o !== exp_req) begin
            failures++;
            $display("FAIL %s_release: got gnt=%b rvalid=%b port_req=%b, expected gnt=1 rvalid=1 port_req=%b",
                     name, gnt_o, rvalid_o, port_req_o, exp_req);
        end
        if (gnt_o === 1'b1) push_exp(exp_port);
    endtask

    task automatic test_reset();
        #1;
        @(negedge clk_i);
        #4;
        checks++;
        if ({gnt_o, rvalid_o, rdata_o, err_o, port_req_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b rvalid=%b rdata=%h err=%b port_req=%b, expected all 0",
                     gnt_o, rvalid_o, rdata_o, err_o, port_req_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        #4;
        checks++;
        if ({gnt_o, rvalid_o, err_o, port_req_o} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle: got gnt=%b rvalid=%b err=%b port_req=%b, expected all 0",
                     gnt_o, rvalid_o, err_o, port_req_o);
        end
    endtask

    task automatic test_basic_read();
        int w;
        issue(64'h78000010, 0, w);
        drain();
    endtask

    task automatic test_boundaries();
        int w;
        issue(64'h781FFFFC, 0, w);
        issue(64'h78200000, 1, w);
        issue(64'h40002FFC, 2, w);
        issue(64'h40003000, NR, w);
        @(negedge clk_i);
        req_i = 1'b0;
        #4;
        checks++;
        if (rvalid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== '0) begin
            failures++;
            $display("FAIL err_timing: got rvalid=%b err=%b rdata=%h one cycle after gnt, expected 1 1 0",
                     rvalid_o, err_o, rdata_o);
        end
        drain();
    endtask

    task automatic test_disabled_rule();
        int w;
        issue(64'h51000000, NR, w);
        drain();
        rule_en_i[3] = 1'b1;
        issue(64'h51000000, 3, w);
        drain();
        rule_en_i[3] = 1'b0;
    endtask

    task automatic test_back_to_back_err();
        int w;
        for (int i = 0; i < 3; i++) begin
            issue(64'h00001000 + 64'(i * 4), NR, w);
            checks++;
            if (w != 0) begin
                failures++;
                $display("FAIL err_b2b: request %0d got %0d stall cycles, expected 0", i, w);
            end
        end
        drain();
    endtask

    task automatic test_max_outstanding();
        int w;
        hold[1] = 1'b1;
        for (int i = 0; i < MO; i++) begin
            issue(64'h78200000 + 64'(i * 4), 1, w);
        end
        stall_then_release(64'h78200040, 1, 1, "max_out");
        drain();
    endtask

    task automatic test_target_switch();
        int w;
        hold[0] = 1'b1;
        issue(64'h78000020, 0, w);
        stall_then_release(64'h40000010, 2, 0, "switch");
        drain();
    endtask

    task automatic test_reset_mid();
        int w;
        hold[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(64'h78200100 + 64'(i * 4), 1, w);
        end
        @(negedge clk_i);
        req_i   = 1'b0;
        rst_ni  = 1'b0;
        hold[1] = 1'b0;
        sb_q.delete();
        for (int k = 0; k < 6; k++) begin
            #4;
            checks++;
            if (rvalid_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_drop: got rvalid=%b during reset, expected 0", rvalid_o);
            end
            @(negedge clk_i);
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        issue(64'h78000030, 0, w);
        checks++;
        if (w != 0) begin
            failures++;
            $display("FAIL reset_recover: got %0d stall cycles after reset, expected 0", w);
        end
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running at 100us, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int p = 0; p < NR; p++) exp_ctr[p] = 0;
        rst_ni      = 1'b0;
        req_i       = 1'b0;
        addr_i      = '0;
        we_i        = 1'b0;
        wdata_i     = '0;
        be_i        = '1;
        port_gnt_i  = '1;
        port_err_i  = '0;
        rule_en_i   = 4'b0111;
        rule_base_i = {64'h51000000, 64'h40000000, 64'h78200000, 64'h78000000};
        rule_size_i = {64'h00800000, 64'h00003000, 64'h00200000, 64'h00200000};

        test_reset();
        test_basic_read();
        test_boundaries();
        test_disabled_rule();
        test_back_to_back_err();
        test_max_outstanding();
        test_target_switch();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
